// File: rtl/uart_tx.sv
// uart_tx -- serial UART transmitter.
//
// Accepts a parallel word over a valid/ready handshake and serialises it onto
// tx as: start bit (0), data bits LSB first, optional parity bit, then one or
// two stop bits (1). Bit timing and parameters match uart_rx.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a parity bit follows the data bits (even, or odd when
//                PARITY_ODD=1), computed from the word at the accept edge.
//   undefined -> no parity state or register; STOP follows DATA directly.
//
// Parameters:
//   CLOCKS_PER_PULSE  clock cycles per bit period (>= 2)
//   BITS_PER_WORD     data bits per frame (>= 1)
//   STOP_BITS         1 or 2
//   PARITY_ODD        0 = even parity, 1 = odd parity (parity builds only)
//
// Ports:
//   clk      in   single clock, rising edge
//   rstn     in   asynchronous active-low reset
//   s_valid  in   upstream word available
//   s_ready  out  transmitter can accept a word (state == IDLE)
//   s_data   in   word to send
//   tx       out  serial line, idles at 1 (registered)
//   busy     out  frame in progress (registered)

module uart_tx #(
   parameter int CLOCKS_PER_PULSE = 5208,
   parameter int BITS_PER_WORD    = 8,
   parameter int STOP_BITS        = 1,
   parameter int PARITY_ODD       = 0
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [BITS_PER_WORD-1:0] s_data,
   output logic                     tx,
   output logic                     busy
);

   localparam int CW = $clog2(CLOCKS_PER_PULSE);
   localparam int BW = $clog2(BITS_PER_WORD) + 1;

   localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_PULSE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   // Elaboration-time parameter sanity checks.
   if (CLOCKS_PER_PULSE < 2) begin : g_bad_cpp
      $error("uart_tx: CLOCKS_PER_PULSE must be >= 2");
   end
   if (BITS_PER_WORD < 1) begin : g_bad_bpw
      $error("uart_tx: BITS_PER_WORD must be >= 1");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
      $error("uart_tx: PARITY_ODD must be 0 or 1");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;
`endif

   state_t                   r_state;
   logic [CW-1:0]            r_clk_cnt;
   logic [BW-1:0]            r_bit_cnt;
   logic [BITS_PER_WORD-1:0] r_shift;
   logic                     r_tx;
   logic                     r_busy;
`ifdef UART_TX_PARITY_EN
   logic                     r_parity;
`endif

   logic [BITS_PER_WORD-1:0] w_shift_next;
   logic                     w_pulse_done;

   // Shifted copy taken as a whole vector so BITS_PER_WORD=1 needs no
   // out-of-range index for "next LSB".
   assign w_shift_next = r_shift >> 1;
   assign w_pulse_done = (r_clk_cnt == CLK_LAST);

   assign s_ready = (r_state == IDLE);
   assign tx      = r_tx;
   assign busy    = r_busy;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (s_valid) begin
                  r_shift   <= s_data;
                  r_tx      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_clk_cnt <= '0;
                  r_state   <= START;
`ifdef UART_TX_PARITY_EN
                  r_parity  <= (^s_data) ^ (PARITY_ODD != 0);
`endif
               end
            end

            START: begin
               if (w_pulse_done) begin
                  r_clk_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_tx      <= r_shift[0];
                  r_state   <= DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end

            DATA: begin
               if (w_pulse_done) begin
                  r_clk_cnt <= '0;
                  if (r_bit_cnt == BIT_LAST) begin
                     r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     r_tx      <= r_parity;
                     r_state   <= PARITY;
`else
                     r_tx      <= 1'b1;
                     r_state   <= STOP;
`endif
                  end else begin
                     r_shift   <= w_shift_next;
                     r_tx      <= w_shift_next[0];
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_pulse_done) begin
                  r_clk_cnt <= '0;
                  r_tx      <= 1'b1;
                  r_state   <= STOP;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
`endif

            // Bit counter is reused here to count stop periods.
            STOP: begin
               if (w_pulse_done) begin
                  r_clk_cnt <= '0;
                  if (r_bit_cnt == STOP_LAST) begin
                     r_bit_cnt <= '0;
                     r_busy    <= 1'b0;
                     r_state   <= IDLE;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
